// File: rtl/clk_div.sv
// Programmable integer clock divider (even/odd ratios) with an enable.
// Ratios 0 and 1, or enable low, pass the reference clock straight through.
module clk_div #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             i_ref_clk,
  input  logic             i_rst_n,
  input  logic             i_clk_en,
  input  logic [WIDTH-1:0] i_div_ratio,
  output logic             o_div_clk
);

  logic [WIDTH-1:0] counter;
  logic             div_reg;
  logic             divide;
  logic [WIDTH-1:0] thresh;

  // Last counter value of the current phase; odd ratios get the longer low phase.
  function automatic logic [WIDTH-1:0] phase_thresh(input logic [WIDTH-1:0] ratio,
                                                    input logic            level);
    logic [WIDTH-1:0] half;
    half = ratio >> 1;
    if (ratio[0] && !level) phase_thresh = half;
    else                    phase_thresh = half - WIDTH'(1);
  endfunction

  assign divide = i_clk_en && (i_div_ratio >= WIDTH'(2));
  assign thresh = phase_thresh(i_div_ratio, div_reg);

  // i_rst_n is active-high despite its name.
  always_ff @(posedge i_ref_clk or posedge i_rst_n) begin
    if (i_rst_n) begin
      counter <= '0;
      div_reg <= 1'b0;
    end else if (!divide) begin
      counter <= '0;
      div_reg <= 1'b0;
    end else if (counter >= thresh) begin
      // >= so a ratio decrease mid-phase ends the phase on this edge
      counter <= '0;
      div_reg <= ~div_reg;
    end else begin
      counter <= counter + WIDTH'(1);
    end
  end

  assign o_div_clk = divide ? div_reg : i_ref_clk;

endmodule

// File: tb/tb_clk_div.sv
// Self-checking bench for clk_div: phase-length model checked on both clock
// levels every cycle, plus directed literal sequences and period measurements.
module tb_clk_div;

  localparam int unsigned WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en  = 1'b0;
  logic [WIDTH-1:0] ratio = '0;
  logic             o_clk;

  int checks = 0;
  int fails  = 0;

  clk_div #(.WIDTH(WIDTH)) dut (
    .i_ref_clk  (clk),
    .i_rst_n    (rst),
    .i_clk_en   (en),
    .i_div_ratio(ratio),
    .o_div_clk  (o_clk)
  );

  always #5 clk = ~clk;

  // Model: output level and number of ref cycles already spent in that level.
  logic m_lvl = 1'b0;
  int   m_elapsed = 0;

  function automatic int phase_len(input int n, input logic lvl);
    if (n % 2 == 0) return n / 2;
    return lvl ? (n - 1) / 2 : (n + 1) / 2;
  endfunction

  function automatic bit model_divide();
    return en && (int'(ratio) >= 2);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst || !model_divide()) begin
      m_lvl     <= 1'b0;
      m_elapsed <= 0;
    end else if (m_elapsed + 1 >= phase_len(int'(ratio), m_lvl)) begin
      m_lvl     <= ~m_lvl;
      m_elapsed <= 0;
    end else begin
      m_elapsed <= m_elapsed + 1;
    end
  end

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: o_div_clk=%b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    logic exp;
    exp = model_divide() ? (rst ? 1'b0 : m_lvl) : clk;
    check_bit("model", o_clk, exp);
  endtask

  // Continuous compare on both halves of the reference period.
  always begin
    @(posedge clk);
    #2 model_check();
  end
  always begin
    @(negedge clk);
    #2 model_check();
  end

  task automatic tick(output logic v);
    @(posedge clk);
    #2 v = o_clk;
  endtask

  task automatic check_seq(input string name, input string bits);
    logic v;
    for (int i = 0; i < bits.len(); i++) begin
      tick(v);
      check_bit(name, v, bits[i] == "1");
    end
  endtask

  // Ticks until the sampled output equals lvl; bounded at 100 cycles.
  task automatic wait_level(input logic lvl, output int cnt);
    logic v;
    cnt = 0;
    do begin
      tick(v);
      cnt++;
    end while (v !== lvl && cnt < 100);
  endtask

  // Skips one full period to let a ratio change settle, then measures one.
  task automatic measure(output int hi, output int lo);
    int c;
    wait_level(1'b0, c);
    wait_level(1'b1, c);
    wait_level(1'b0, c);
    wait_level(1'b1, c);
    wait_level(1'b0, hi);
    wait_level(1'b1, lo);
  endtask

  task automatic drive(input logic e, input int n);
    @(negedge clk);
    en    = e;
    ratio = WIDTH'(n);
  endtask

  initial begin
    int   hi, lo, n;
    logic v;

    // Reset with bypass: output tracks the reference clock.
    repeat (3) @(posedge clk);
    #2 check_bit("rst_bypass_hi", o_clk, 1'b1);
    @(negedge clk);
    #2 check_bit("rst_bypass_lo", o_clk, 1'b0);

    // Divide mode while in reset: output held low.
    drive(1'b1, 4);
    @(posedge clk);
    #2 check_bit("rst_divide_low", o_clk, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    check_seq("n4_start", "01100110");

    // Ratio 4 -> 5: settles to low 3, high 2.
    drive(1'b1, 5);
    measure(hi, lo);
    check_int("n5_high_cycles", hi, 2);
    check_int("n5_low_cycles", lo, 3);
    measure(hi, lo);
    check_int("n4_n5_period", hi + lo, 5);

    // Ratio decrease late in a long low phase must end it on the next edge.
    drive(1'b1, 15);
    repeat (20) @(posedge clk);
    drive(1'b1, 2);
    repeat (6) @(posedge clk);

    // Bypass with N=3, then re-enable from a fresh low phase.
    drive(1'b0, 3);
    @(posedge clk);
    #2 check_bit("bypass_n3_hi", o_clk, 1'b1);
    @(negedge clk);
    #2 check_bit("bypass_n3_lo", o_clk, 1'b0);
    repeat (3) @(posedge clk);
    drive(1'b1, 3);
    check_seq("n3_reenable", "01001001");

    // Ratios 0 and 1 bypass even when enabled.
    for (int r = 0; r < 2; r++) begin
      drive(1'b1, r);
      @(posedge clk);
      #2 check_bit("ratio_lt2_hi", o_clk, 1'b1);
      @(negedge clk);
      #2 check_bit("ratio_lt2_lo", o_clk, 1'b0);
    end

    // Maximum ratio: low 8, high 7.
    drive(1'b1, 15);
    measure(hi, lo);
    check_int("n15_high_cycles", hi, 7);
    check_int("n15_low_cycles", lo, 8);

    // Asynchronous reset during a high phase, then restart of the N=4 sequence.
    drive(1'b1, 4);
    n = 0;
    do begin
      tick(v);
      n++;
    end while (v !== 1'b1 && n < 20);
    check_bit("n4_reach_high", v, 1'b1);
    #1 rst = 1'b1;
    #1 check_bit("async_rst_low", o_clk, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    check_seq("n4_after_rst", "01100110");

    repeat (4) @(posedge clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/clk_div.md
# clk_div

Integer clock divider producing a divided clock from a reference clock, with a runtime-programmable ratio and an enable. The ratio can be even or odd. When disabled, or when the ratio is 0 or 1, the reference clock passes straight through. It sits in the clocking block and feeds downstream logic that needs a slower, programmable clock.

## Interface
- WIDTH, 4: bit width of the division ratio; maximum ratio is 2^WIDTH-1.
- i_ref_clk  input  1  reference clock; all state updates on its rising edge.
- i_rst_n  input  1  reset, asynchronous, active-high (asserted = 1); name kept for codebase consistency.
- i_clk_en  input  1  1 = divide; 0 = bypass.
- i_div_ratio  input  WIDTH  division ratio N, unsigned.
- o_div_clk  output  1  divided clock, or i_ref_clk in bypass.

## Operation
- Divide mode: i_clk_en=1 and N>=2. Otherwise the block is in bypass: o_div_clk = i_ref_clk (combinational mux).
- Internal state:
  - counter, WIDTH bits.
  - div_reg, 1 bit.
  - o_div_clk = div_reg in divide mode.
- Even N, 50% duty: counter increments each rising edge. When counter >= N/2-1, div_reg toggles and counter clears.
- Odd N: low phase lasts (N+1)/2 cycles and high phase (N-1)/2 cycles.
  - While div_reg=0: toggle and clear when counter >= (N-1)/2.
  - While div_reg=1: toggle and clear when counter >= (N-1)/2-1.
- The threshold compare is >=, never ==. A ratio decrease mid-phase must end the phase on the next edge, with no counter wrap or lockup.
- In bypass, counter and div_reg are held at 0. Re-entering divide mode starts a fresh low phase.
- i_div_ratio and i_clk_en are sampled every rising edge. There is no shadow register: a new ratio takes effect at the next phase compare.
- Half threshold is computed as N>>1 in WIDTH bits. Parity is taken from N[0].

## Timing
- Reset asserted (asynchronous): counter=0 and div_reg=0.
  - o_div_clk = 0 if the mode is divide, else it follows i_ref_clk.
- First edge after reset release with N=4: div_reg rises on the 2nd rising edge and falls on the 4th. Period is 4 ref cycles.
- N=5: low for 3 cycles, high for 2; period is 5 ref cycles.
- div_reg transitions occur only on i_ref_clk rising edges, with one flop of latency from the compare.
- Mode switch is a combinational mux; a glitch at the switch instant is acceptable.
- Reset asserted mid-operation: div_reg goes to 0 immediately, without waiting for a clock edge.

## Structure
- No shared package needed. The only constant is WIDTH, as a module parameter.
- Single module: counter, phase-compare logic, div_reg flop, and bypass mux.
- No sub-module is required. Optionally, the even/odd threshold computation may be a small function inside the module.

## Test plan
- Reset pulse, i_clk_en=0 -> o_div_clk tracks i_ref_clk (10 ns period); div_reg=0.
- i_clk_en=1, N=4, 10 ns ref -> o_div_clk period 40 ns, high 20 ns, first rise on the 2nd edge after enable.
- N changed 4->5 while enabled -> within one output period, the output settles to period 50 ns (low 30, high 20), with no stuck output.
- i_clk_en=0, N=3 -> o_div_clk identical to i_ref_clk. Re-enable -> output starts low and the first rise comes after 2 edges.
- N=0 and N=1 with i_clk_en=1 -> bypass; N=15 -> period 150 ns, low 80, high 70.
- Reset asserted mid-high phase -> div_reg goes to 0 asynchronously. After release, the N=4 sequence restarts from the low phase.
